code_search_ctrl: RTL and testbench

Sequencer for a serial C/A code-phase search. It drives one channel's code generator through its configuration inputs: PRN key load, then code slew per search bin. Per-dump correlation energy is integrated over a programmable dwell per bin, and the bin with peak energy is reported. It sits between the host register interface and the channel's code generator and accumulator.

---
 rtl/code_search_ctrl_if.sv | 39 +++
 rtl/code_search_ctrl.sv | 150 +++++++++++++++
 tb/tb_code_search_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_search_ctrl_if.sv
// Signal bundle between the host/code generator (master) and code_search_ctrl (slave).
// Widths track the controller's DWELL_W and ENERGY_W parameters.
interface code_search_ctrl_if #(
  parameter int DWELL_W  = 8,
  parameter int ENERGY_W = 32
);
  logic                         start;
  logic                         abort;
  logic [9:0]                   prn_key_in;
  logic [10:0]                  step;
  logic [11:0]                  num_bins;
  logic [DWELL_W-1:0]           dwell;
  logic                         dump_enable;
  logic                         energy_valid;
  logic [ENERGY_W-1:0]          energy;
  logic                         prn_key_enable;
  logic [9:0]                   prn_key;
  logic                         slew_enable;
  logic [10:0]                  code_slew;
  logic                         busy;
  logic                         done;
  logic [11:0]                  bin_index;
  logic [11:0]                  best_bin;
  logic [ENERGY_W+DWELL_W-1:0]  best_energy;

  modport master (
    output start, abort, prn_key_in, step, num_bins, dwell,
           dump_enable, energy_valid, energy,
    input  prn_key_enable, prn_key, slew_enable, code_slew,
           busy, done, bin_index, best_bin, best_energy
  );

  modport slave (
    input  start, abort, prn_key_in, step, num_bins, dwell,
           dump_enable, energy_valid, energy,
    output prn_key_enable, prn_key, slew_enable, code_slew,
           busy, done, bin_index, best_bin, best_energy
  );
endinterface

// File: rtl/code_search_ctrl.sv
// Serial code-phase search sequencer: PRN load, settle, dwell integration, peak pick, slew per bin.
// Latency: load 1 cycle after start, done 2 cycles after the last energy; no backpressure, paced by dumps.
module code_search_ctrl #(
  parameter int DWELL_W  = 8,
  parameter int ENERGY_W = 32,
  parameter int SETTLE   = 2
) (
  input  logic               clk,
  input  logic               rstn,
  code_search_ctrl_if.slave  bus
);
  localparam int AW = ENERGY_W + DWELL_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_DWELL, S_CMP, S_SLEW, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [9:0]         key_q;
  logic [10:0]        step_q;
  logic [11:0]        nbins_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [2:0]         settle_cnt;
  logic [AW-1:0]      acc;
  logic               slew_pend;
  logic [10:0]        slew_q;
  logic [11:0]        bin_q;
  logic [11:0]        best_bin_q;
  logic [AW-1:0]      best_q;

  logic start_ok, degenerate, settled, last_sample, last_bin, better;

  assign start_ok    = bus.start && !bus.abort;
  assign degenerate  = (bus.num_bins == 12'd0) || (bus.dwell == '0);
  assign settled     = settle_cnt == 3'(SETTLE - 1);
  assign last_sample = dwell_cnt == dwell_q - DWELL_W'(1);
  assign last_bin    = bin_q == nbins_q - 12'd1;
  // strict compare keeps the earlier bin on a tie
  assign better      = (bin_q == 12'd0) || (acc > best_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != S_IDLE && bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_ok) state_nxt = degenerate ? S_DONE : S_LOAD;
        S_LOAD:   state_nxt = S_SETTLE;
        S_SETTLE: if (bus.dump_enable && settled) state_nxt = S_DWELL;
        S_DWELL:  if (bus.energy_valid && last_sample) state_nxt = S_CMP;
        S_CMP:    state_nxt = last_bin ? S_DONE : S_SLEW;
        S_SLEW:   if (slew_pend) state_nxt = S_SETTLE;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_q      <= '0;
      step_q     <= '0;
      nbins_q    <= '0;
      dwell_q    <= '0;
      dwell_cnt  <= '0;
      settle_cnt <= '0;
      acc        <= '0;
      slew_pend  <= 1'b0;
      slew_q     <= '0;
      bin_q      <= '0;
      best_bin_q <= '0;
      best_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            key_q   <= bus.prn_key_in;
            step_q  <= bus.step;
            nbins_q <= bus.num_bins;
            dwell_q <= bus.dwell;
            if (degenerate) begin
              best_q     <= '0;
              best_bin_q <= '0;
            end
          end
        end
        S_LOAD: begin
          bin_q      <= '0;
          best_bin_q <= '0;
          best_q     <= '0;
          acc        <= '0;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          if (bus.dump_enable) begin
            if (settled) begin
              acc       <= '0;
              dwell_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 3'd1;
            end
          end
        end
        S_DWELL: begin
          if (bus.energy_valid) begin
            acc       <= acc + AW'(bus.energy);
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        S_CMP: begin
          slew_pend <= 1'b0;
          if (!bus.abort && better) begin
            best_q     <= acc;
            best_bin_q <= bin_q;
          end
        end
        S_SLEW: begin
          // slew is issued the cycle after the dump so it never coincides with one
          if (bus.abort) begin
            slew_pend <= 1'b0;
          end else if (slew_pend) begin
            slew_pend  <= 1'b0;
            bin_q      <= bin_q + 12'd1;
            settle_cnt <= '0;
          end else if (bus.dump_enable) begin
            slew_pend <= 1'b1;
            slew_q    <= step_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.prn_key_enable = state == S_LOAD;
  assign bus.prn_key        = key_q;
  assign bus.slew_enable    = slew_pend;
  assign bus.code_slew      = slew_q;
  assign bus.busy           = state inside {S_LOAD, S_SETTLE, S_DWELL, S_CMP, S_SLEW};
  assign bus.done           = state == S_DONE;
  assign bus.bin_index      = bin_q;
  assign bus.best_bin       = best_bin_q;
  assign bus.best_energy    = best_q;
endmodule

// File: tb/tb_code_search_ctrl.sv
// Directed bench for code_search_ctrl: per-cycle vector table plus hand-written search sequences.
module tb_code_search_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   slew_cnt = 0;
  int   done_cnt = 0;
  logic prev_dump = 1'b0;

  code_search_ctrl_if #(.DWELL_W(8), .ENERGY_W(32)) bus ();

  code_search_ctrl #(.DWELL_W(8), .ENERGY_W(32), .SETTLE(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ctl = {start, abort, dump, ev}; flg = {prn_key_enable, slew_enable, busy, done}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] energy;
    logic [11:0] nbins;
    logic [7:0]  dwell;
    logic [3:0]  flg;
    logic [11:0] bb;
    logic [39:0] be;
    logic [9:0]  key;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic d, input logic v, input logic [31:0] e);
    bus.dump_enable  = d;
    bus.energy_valid = v;
    bus.energy       = e;
    @(posedge clk);
    #1;
    bus.dump_enable  = 1'b0;
    bus.energy_valid = 1'b0;
    bus.energy       = '0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
  endtask

  task automatic idle1();
    cyc(1'b0, 1'b0, 32'd0);
  endtask

  task automatic dump1();
    cyc(1'b1, 1'b0, 32'd0);
  endtask

  task automatic ev1(input logic [31:0] e);
    cyc(1'b0, 1'b1, e);
  endtask

  // two settle dumps, two samples, then the compare cycle
  task automatic do_bin(input logic [31:0] e1, input logic [31:0] e2);
    dump1();
    dump1();
    ev1(e1);
    idle1();
    ev1(e2);
    idle1();
  endtask

  task automatic start_search(input logic [9:0] key, input logic [11:0] nb, input logic [7:0] dw);
    bus.prn_key_in = key;
    bus.step       = 11'd2;
    bus.num_bins   = nb;
    bus.dwell      = dw;
    bus.start      = 1'b1;
    idle1();
  endtask

  // every slew pulse must follow a dump by one cycle, never share a cycle with one
  always @(negedge clk) begin
    if (rstn && bus.slew_enable) begin
      slew_cnt++;
      chk("slew_after_dump", 64'({prev_dump, bus.dump_enable}), 64'(2'b10));
      chk("slew_amount", 64'(bus.code_slew), 64'(11'd2));
    end
    if (rstn && bus.done) done_cnt++;
    prev_dump <= bus.dump_enable;
  end

  initial begin
    int s0;
    int d0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.prn_key_in = 10'h3EC;
    bus.step = 11'd2;
    bus.num_bins = 12'd1;
    bus.dwell = 8'd1;
    bus.dump_enable = 1'b0;
    bus.energy_valid = 1'b0;
    bus.energy = '0;

    #12;
    chk("reset_flags", 64'({bus.prn_key_enable, bus.slew_enable, bus.busy, bus.done}), 64'(4'b0000));
    chk("reset_key", 64'(bus.prn_key), 64'(10'd0));
    chk("reset_best", 64'(bus.best_energy), 64'(40'd0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // single bin, ignored start+abort, degenerate starts
    vt[0]  = '{4'b1000, 32'd0,   12'd1, 8'd1, 4'b1010, 12'd0, 40'd0,   10'h3EC};
    vt[1]  = '{4'b0000, 32'd0,   12'd1, 8'd1, 4'b0010, 12'd0, 40'd0,   10'h3EC};
    vt[2]  = '{4'b0010, 32'd0,   12'd1, 8'd1, 4'b0010, 12'd0, 40'd0,   10'h3EC};
    vt[3]  = '{4'b0010, 32'd0,   12'd1, 8'd1, 4'b0010, 12'd0, 40'd0,   10'h3EC};
    vt[4]  = '{4'b0001, 32'd100, 12'd1, 8'd1, 4'b0010, 12'd0, 40'd0,   10'h3EC};
    vt[5]  = '{4'b0000, 32'd0,   12'd1, 8'd1, 4'b0001, 12'd0, 40'd100, 10'h3EC};
    vt[6]  = '{4'b0000, 32'd0,   12'd1, 8'd1, 4'b0000, 12'd0, 40'd100, 10'h3EC};
    vt[7]  = '{4'b1100, 32'd0,   12'd1, 8'd1, 4'b0000, 12'd0, 40'd100, 10'h3EC};
    vt[8]  = '{4'b1000, 32'd0,   12'd1, 8'd0, 4'b0001, 12'd0, 40'd0,   10'h3EC};
    vt[9]  = '{4'b0000, 32'd0,   12'd1, 8'd0, 4'b0000, 12'd0, 40'd0,   10'h3EC};
    vt[10] = '{4'b1000, 32'd0,   12'd0, 8'd3, 4'b0001, 12'd0, 40'd0,   10'h3EC};
    vt[11] = '{4'b0000, 32'd0,   12'd0, 8'd3, 4'b0000, 12'd0, 40'd0,   10'h3EC};

    s0 = slew_cnt;
    for (int i = 0; i < 12; i++) begin
      {bus.start, bus.abort, bus.dump_enable, bus.energy_valid} = vt[i].ctl;
      bus.energy   = vt[i].energy;
      bus.num_bins = vt[i].nbins;
      bus.dwell    = vt[i].dwell;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_flags", i), 64'({bus.prn_key_enable, bus.slew_enable, bus.busy, bus.done}), 64'(vt[i].flg));
      chk($sformatf("vec%0d_best_bin", i), 64'(bus.best_bin), 64'(vt[i].bb));
      chk($sformatf("vec%0d_best_energy", i), 64'(bus.best_energy), 64'(vt[i].be));
      chk($sformatf("vec%0d_prn_key", i), 64'(bus.prn_key), 64'(vt[i].key));
    end
    {bus.start, bus.abort, bus.dump_enable, bus.energy_valid} = 4'b0000;
    chk("single_no_slew", 64'(slew_cnt - s0), 64'(0));

    // four bins with a tie between bins 1 and 2; a stray start arrives mid-search
    s0 = slew_cnt;
    start_search(10'h1A5, 12'd4, 8'd2);
    chk("multi_load", 64'({bus.prn_key_enable, bus.busy}), 64'(2'b11));
    idle1();
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin
        bus.prn_key_in = 10'h155;
        bus.num_bins   = 12'd1;
        bus.dwell      = 8'd1;
        bus.start      = 1'b1;
        idle1();
        chk("busy_start_ignored", 64'({bus.prn_key_enable, bus.busy}), 64'(2'b01));
      end
      case (b)
        0:       do_bin(32'd4,  32'd6);
        1:       do_bin(32'd20, 32'd30);
        2:       do_bin(32'd25, 32'd25);
        default: do_bin(32'd15, 32'd5);
      endcase
      if (b < 3) begin
        dump1();
        chk($sformatf("multi_slew_b%0d", b), 64'(bus.slew_enable), 64'(1));
        idle1();
        chk($sformatf("multi_bin_idx_b%0d", b), 64'(bus.bin_index), 64'(b + 1));
      end
    end
    chk("multi_done", 64'({bus.done, bus.busy}), 64'(2'b10));
    chk("multi_best_bin", 64'(bus.best_bin), 64'(12'd1));
    chk("multi_best_energy", 64'(bus.best_energy), 64'(40'd50));
    chk("multi_bin_index", 64'(bus.bin_index), 64'(12'd3));
    chk("multi_prn_key", 64'(bus.prn_key), 64'(10'h1A5));
    chk("multi_slew_count", 64'(slew_cnt - s0), 64'(3));
    idle1();

    // abort during bin 2 dwell
    start_search(10'h0F0, 12'd4, 8'd2);
    idle1();
    do_bin(32'd30, 32'd10);
    dump1();
    idle1();
    do_bin(32'd40, 32'd30);
    dump1();
    idle1();
    dump1();
    dump1();
    ev1(32'd99);
    s0 = slew_cnt;
    d0 = done_cnt;
    bus.abort = 1'b1;
    idle1();
    chk("abort_busy_done", 64'({bus.busy, bus.done}), 64'(2'b00));
    chk("abort_best_bin", 64'(bus.best_bin), 64'(12'd1));
    chk("abort_best_energy", 64'(bus.best_energy), 64'(40'd70));
    chk("abort_bin_index", 64'(bus.bin_index), 64'(12'd2));
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0)      dump1();
      else if (i % 3 == 1) ev1(32'd5);
      else                 idle1();
    end
    chk("abort_no_slew", 64'(slew_cnt - s0), 64'(0));
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    chk("abort_stays_idle", 64'(bus.busy), 64'(0));

    // accumulator width: 255 samples of all-ones
    start_search(10'h3FF, 12'd1, 8'd255);
    idle1();
    dump1();
    dump1();
    for (int i = 0; i < 255; i++) ev1(32'hFFFF_FFFF);
    idle1();
    chk("acc_done", 64'(bus.done), 64'(1));
    chk("acc_best_energy", 64'(bus.best_energy), 64'(40'hFE_FFFF_FF01));
    idle1();

    // asynchronous reset in the middle of a slew
    start_search(10'h2A1, 12'd2, 8'd1);
    idle1();
    dump1();
    dump1();
    ev1(32'd7);
    idle1();
    dump1();
    chk("pre_reset_slew", 64'({bus.slew_enable, bus.busy}), 64'(2'b11));
    chk("pre_reset_best", 64'(bus.best_energy), 64'(40'd7));
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_flags", 64'({bus.prn_key_enable, bus.slew_enable, bus.busy, bus.done}), 64'(4'b0000));
    chk("arst_key_slew", 64'({bus.prn_key, bus.code_slew}), 64'(0));
    chk("arst_bins", 64'({bus.bin_index, bus.best_bin}), 64'(0));
    chk("arst_best_energy", 64'(bus.best_energy), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", 64'({bus.busy, bus.slew_enable}), 64'(2'b00));
    start_search(10'h2A1, 12'd1, 8'd1);
    chk("post_reset_load", 64'({bus.prn_key_enable, bus.prn_key}), 64'({1'b1, 10'h2A1}));
    idle1();
    dump1();
    dump1();
    ev1(32'd55);
    idle1();
    chk("post_reset_done", 64'(bus.done), 64'(1));
    chk("post_reset_best", 64'(bus.best_energy), 64'(40'd55));
    idle1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
